// File: rtl/xc_rf_banked.sv
// xc_rf_banked: odd/even-banked register file with post-reset clear sequencer,
// optional write-to-read bypass and misaligned wide-write error pulse.
module xc_rf_banked #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_rdata,
    input  logic                rd_wen,
    input  logic                rd_wide,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_wdata,
    input  logic [XLEN-1:0]     rd_wdata_hi,
    output logic                wide_err
);
    localparam int HALF = NREGS / 2;
    localparam int IW   = AW - 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic            run_w, we_even, we_odd, err_nxt;
    logic [XLEN-1:0] wd_odd;
    logic [XLEN-1:0] even_bank [HALF];
    logic [XLEN-1:0] odd_bank  [HALF];

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CLEAR;
            cnt      <= '0;
            wide_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= (state == CLEAR) ? cnt + 1'b1 : cnt;
            wide_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = (state == CLEAR && cnt == IW'(HALF - 1)) ? RUN : state;
    end

    always_comb begin
        ready = (state == RUN);
    end

    // Wide writes pair even[idx] (low word) with odd[idx] (high word); reg 0 is never stored.
    always_comb begin
        idx     = rd_addr[AW-1:1];
        run_w   = ready & rd_wen & ~reset;
        we_even = run_w & ~rd_addr[0] & (idx != '0);
        we_odd  = run_w & (rd_wide ^ rd_addr[0]);
        err_nxt = run_w & rd_wide & rd_addr[0];
        wd_odd  = rd_wide ? rd_wdata_hi : rd_wdata;
    end

    always_ff @(posedge clock) begin
        if (state == CLEAR && !reset) begin
            even_bank[cnt] <= '0;
            odd_bank[cnt]  <= '0;
        end else begin
            if (we_even) even_bank[idx] <= rd_wdata;
            if (we_odd)  odd_bank[idx]  <= wd_odd;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] stored;
        logic            hit_e, hit_o;
        always_comb begin
            a      = rs_addr[g*AW +: AW];
            stored = a[0] ? odd_bank[a[AW-1:1]] : even_bank[a[AW-1:1]];
            hit_e  = (BYPASS != 0) && we_even && !a[0] && a[AW-1:1] == idx;
            hit_o  = (BYPASS != 0) && we_odd && a[0] && a[AW-1:1] == idx;
            rs_rdata[g*XLEN +: XLEN] = (!ready || a == '0) ? '0 :
                                       hit_e ? rd_wdata :
                                       hit_o ? wd_odd : stored;
        end
    end
endmodule

// File: tb/tb_xc_rf_banked.sv
// tb_xc_rf_banked: directed stimulus with a cycle-tagged scoreboard queue drained by a monitor.
module tb_xc_rf_banked;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ready, ready_nb;
    logic [9:0]  rs_addr = '0;
    logic [63:0] rs_rdata, rs_rdata_nb;
    logic        rd_wen = 1'b0;
    logic        rd_wide = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_wdata = '0;
    logic [31:0] rd_wdata_hi = '0;
    logic        wide_err, wide_err_nb;

    xc_rf_banked #(.BYPASS(1)) dut (
        .clock(clock), .reset(reset), .ready(ready), .rs_addr(rs_addr), .rs_rdata(rs_rdata),
        .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .rd_wdata_hi(rd_wdata_hi), .wide_err(wide_err)
    );

    xc_rf_banked #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .ready(ready_nb), .rs_addr(rs_addr), .rs_rdata(rs_rdata_nb),
        .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .rd_wdata_hi(rd_wdata_hi), .wide_err(wide_err_nb)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] got;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0: return rs_rdata[31:0];
            1: return rs_rdata[63:32];
            2: return {31'b0, ready};
            3: return {31'b0, wide_err};
            4: return rs_rdata_nb[31:0];
            default: return {31'b0, ready_nb};
        endcase
    endfunction

    // Monitor: at each falling edge, check every expectation tagged for this cycle.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            got = pick(e.sel);
            n_cmp++;
            if (e.cyc < cyc) begin
                n_err++;
                $display("FAIL %s: missed sample (cycle %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h required %h", e.name, got, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input int sel, input logic [31:0] exp, input string name);
        exp_t x;
        x.cyc = cyc;
        x.sel = sel;
        x.exp = exp;
        x.name = name;
        q.push_back(x);
    endtask

    task automatic rd(input int a0, input int a1);
        rs_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic wr(input logic wen, input logic wide, input int a,
                      input logic [31:0] lo, input logic [31:0] hi);
        rd_wen = wen;
        rd_wide = wide;
        rd_addr = 5'(a);
        rd_wdata = lo;
        rd_wdata_hi = hi;
    endtask

    task automatic do_reset_clear(input string tag);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(5, 9);
        for (int i = 0; i < 16; i++) begin
            wr(1'b1, 1'b0, 5, 32'hDEADBEEF, 32'h0);
            chk(2, 0, $sformatf("%s ready_low_%0d", tag, i));
            chk(5, 0, $sformatf("%s nb_ready_low_%0d", tag, i));
            chk(0, 0, $sformatf("%s clear_rdata_%0d", tag, i));
            chk(3, 0, $sformatf("%s clear_no_err_%0d", tag, i));
            if (i == 15) wr(1'b0, 1'b0, 0, 0, 0);
            tick();
        end
        chk(2, 1, $sformatf("%s ready_high", tag));
    endtask

    task automatic sweep(input string tag);
        for (int r = 0; r < 32; r += 2) begin
            rd(r, r + 1);
            chk(0, 0, $sformatf("%s r%0d", tag, r));
            chk(1, 0, $sformatf("%s r%0d", tag, r + 1));
            chk(4, 0, $sformatf("%s nb r%0d", tag, r));
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        do_reset_clear("rst1");
        sweep("zero1");

        // Wide aligned write r6/r7, both halves forwarded in the write cycle
        wr(1'b1, 1'b1, 6, 32'h11111111, 32'h22222222);
        rd(6, 7);
        chk(0, 32'h11111111, "wide6 bypass lo");
        chk(1, 32'h22222222, "wide6 bypass hi");
        chk(4, 32'h0, "wide6 nobypass old");
        tick();
        wr(1'b0, 1'b0, 0, 0, 0);
        chk(0, 32'h11111111, "wide6 r6");
        chk(1, 32'h22222222, "wide6 r7");
        chk(4, 32'h11111111, "wide6 nb r6");
        chk(3, 0, "wide6 no err");

        // Misaligned wide write: nothing written, not forwarded, one-cycle error
        tick();
        wr(1'b1, 1'b1, 7, 32'h33333333, 32'h44444444);
        chk(0, 32'h11111111, "wide7 no fwd r6");
        chk(1, 32'h22222222, "wide7 no fwd r7");
        chk(3, 0, "wide7 err not yet");
        tick();
        wr(1'b0, 1'b0, 0, 0, 0);
        chk(3, 1, "wide7 err pulse");
        chk(0, 32'h11111111, "wide7 r6 kept");
        chk(1, 32'h22222222, "wide7 r7 kept");
        tick();
        chk(3, 0, "wide7 err cleared");

        // Narrow write with bypass vs. no bypass
        tick();
        wr(1'b1, 1'b0, 9, 32'hCAFEF00D, 0);
        rd(9, 9);
        chk(0, 32'hCAFEF00D, "r9 bypass p0");
        chk(1, 32'hCAFEF00D, "r9 bypass p1");
        chk(4, 32'h0, "r9 nobypass old");
        tick();
        wr(1'b0, 1'b0, 0, 0, 0);
        chk(4, 32'hCAFEF00D, "r9 nobypass new");
        chk(0, 32'hCAFEF00D, "r9 stored");

        // Narrow even write, and wide hi-only at address 0
        tick();
        wr(1'b1, 1'b0, 12, 32'h12345678, 0);
        rd(8, 12);
        chk(1, 32'h12345678, "r12 bypass");
        chk(0, 32'h0, "r8 untouched");
        tick();
        wr(1'b1, 1'b1, 0, 32'hAAAAAAAA, 32'h55555555);
        rd(0, 1);
        chk(0, 32'h0, "wide0 r0 zero");
        chk(1, 32'h55555555, "wide0 r1 bypass");
        tick();
        wr(1'b1, 1'b0, 0, 32'hFFFFFFFF, 0);
        chk(0, 32'h0, "r0 write bypass zero");
        chk(1, 32'h55555555, "wide0 r1 stored");
        chk(4, 32'h0, "r0 nb zero");
        tick();
        wr(1'b0, 1'b0, 0, 0, 0);
        rd(0, 12);
        chk(0, 32'h0, "r0 stays zero");
        chk(1, 32'h12345678, "r12 stored");
        tick();

        // Reset in the middle of CLEAR (cnt=8)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk(2, 0, $sformatf("partial clear ready_low_%0d", i));
            tick();
        end
        do_reset_clear("rst_mid");
        sweep("zero2");

        // Populate a few registers in RUN, then reset and expect a full clear
        wr(1'b1, 1'b1, 6, 32'h0BADF00D, 32'h600DCAFE);
        tick();
        wr(1'b1, 1'b0, 9, 32'h99999999, 0);
        tick();
        wr(1'b0, 1'b0, 0, 0, 0);
        rd(7, 9);
        chk(0, 32'h600DCAFE, "pre-reset r7");
        chk(1, 32'h99999999, "pre-reset r9");
        tick();
        do_reset_clear("rst_run");
        sweep("zero3");

        tick();
        tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: got %0d pending required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
